// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, frame length and baud divisor helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        S_HOLDOFF = 2'd0,
        S_IDLE    = 2'd1,
        S_WAIT    = 2'd2
    } sched_state_t;

    // Start bit plus stop bit around the data bits.
    localparam int FRAME_OVERHEAD_BITS = 2;

    function automatic int frame_bits(input int nb_data);
        return nb_data + FRAME_OVERHEAD_BITS;
    endfunction

    function automatic int clks_per_bit(input longint clock_freq, input longint baud_rate);
        return int'((clock_freq + baud_rate - 1) / baud_rate);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, scanning upward with wrap.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IW'(sum);
    endfunction

    // rot[i] is the request sitting i positions after the pointer.
    logic [N-1:0] rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[wrap_add(ptr, gi)];
        end
    endgenerate

    always_comb begin
        logic found;
        found = 1'b0;
        idx   = '0;
        grant = '0;
        any   = |req;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx serializer between N_REQ byte producers,
// with a power-up holdoff and a completion watchdog.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    output logic [N_REQ-1:0]         o_ack,
    output logic [N_REQ-1:0]         o_done,
    output logic                     o_error,
    output logic                     o_busy,
    output logic                     o_tx_valid,
    output logic [NB_DATA-1:0]       o_tx_data,
    input  logic                     i_tx_done
);
    localparam int FRAME_CYCLES   = CLKS_PER_BIT * frame_bits(NB_DATA);
    localparam int TIMEOUT_CYCLES = 2 * FRAME_CYCLES;
    localparam int CW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW             = $clog2(N_REQ);

    sched_state_t       state_reg, state_next;
    logic [IW-1:0]      ptr_reg, ptr_next;
    logic [IW-1:0]      owner_reg, owner_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               done_q_reg;
    logic [N_REQ-1:0]   ack_reg, ack_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic               error_reg, error_next;
    logic               tx_valid_reg, tx_valid_next;
    logic [NB_DATA-1:0] tx_data_reg, tx_data_next;

    logic [N_REQ-1:0]   pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               done_evt;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (i_req),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign done_evt = i_tx_done & ~done_q_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_HOLDOFF;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            cnt_reg      <= '0;
            done_q_reg   <= 1'b0;
            ack_reg      <= '0;
            done_reg     <= '0;
            error_reg    <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            cnt_reg      <= cnt_next;
            done_q_reg   <= i_tx_done;
            ack_reg      <= ack_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        cnt_next      = cnt_reg;
        ack_next      = '0;
        done_next     = '0;
        error_next    = 1'b0;
        tx_valid_next = 1'b0;
        tx_data_next  = tx_data_reg;

        case (state_reg)
            S_HOLDOFF: begin
                // The serializer has no reset: let any frame already on the line drain.
                if (cnt_reg == CW'(FRAME_CYCLES - 1)) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_IDLE: begin
                cnt_next = '0;
                if (pick_any) begin
                    ack_next      = pick_grant;
                    tx_valid_next = 1'b1;
                    tx_data_next  = i_data[pick_idx*NB_DATA +: NB_DATA];
                    owner_next    = pick_idx;
                    ptr_next      = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg + CW'(1);
                // An edge during the launch cycle predates this frame and is ignored.
                if (done_evt && !tx_valid_reg) begin
                    done_next[owner_reg] = 1'b1;
                    state_next           = S_IDLE;
                    cnt_next             = '0;
                end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    error_next = 1'b1;
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_HOLDOFF;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_ack      = ack_reg;
    assign o_done     = done_reg;
    assign o_error    = error_reg;
    assign o_busy     = (state_reg != S_IDLE);
    assign o_tx_valid = tx_valid_reg;
    assign o_tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: behavioural serializer stub, scoreboard of
// expected launches, a table of arbitration vectors and hand-written corner sequences.
module tb_uart_tx_scheduler;
    localparam int NB      = 8;
    localparam int NR      = 4;
    localparam int CPB     = 87;
    localparam int FRAME   = CPB * (NB + 2);
    localparam int TIMEOUT = 2 * FRAME;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     i_req;
    logic [NR*NB-1:0]  i_data;
    logic [NR-1:0]     o_ack;
    logic [NR-1:0]     o_done;
    logic              o_error;
    logic              o_busy;
    logic              o_tx_valid;
    logic [NB-1:0]     o_tx_data;
    logic              tx_done;

    uart_tx_scheduler #(.NB_DATA(NB), .N_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_busy     (o_busy),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc;
    always @(posedge clock) cyc <= cyc + 1;

    // Serializer stub: o_valid drops after a launch and rises stub_delay cycles later.
    bit stub_clr;
    bit stub_run;
    bit stub_hang;
    int stub_cnt;
    int stub_delay;
    always @(posedge clock) begin
        if (stub_clr) begin
            tx_done  <= 1'b1;
            stub_run <= 1'b0;
            stub_cnt <= 0;
        end else if (o_tx_valid) begin
            tx_done  <= 1'b0;
            stub_cnt <= 0;
            stub_run <= 1'b1;
        end else if (stub_run) begin
            stub_cnt <= stub_cnt + 1;
            if (!stub_hang && stub_cnt == stub_delay - 1) begin
                tx_done  <= 1'b1;
                stub_run <= 1'b0;
            end
        end
    end

    int n_checks;
    int n_bad;

    typedef struct {
        int           idx;
        logic [NB-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*NB-1:0] dat;
        int               idx;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int idx, input logic [NB-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name, input int budget, output int ack_cyc, output bit stray);
        exp_t e;
        logic [NR-1:0] onehot;
        ack_cyc = -1;
        stray   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (o_done != 0 || o_error) stray = 1'b1;
            if (o_ack != 0) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL %s_ack: got none within %0d cycles, want an ack", name, budget);
        end else if (sb.size() == 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL %s_ack: got ack %b, want none (scoreboard empty)", name, o_ack);
        end else begin
            e = sb.pop_front();
            onehot = '0;
            onehot[e.idx] = 1'b1;
            check({name, "_ack"}, o_ack, onehot);
            check({name, "_valid"}, o_tx_valid, 1);
            check({name, "_data"}, o_tx_data, e.data);
            $display("launch %s: req=%0d data=%02h cycle=%0d", name, e.idx, o_tx_data, cyc);
        end
    endtask

    task automatic wait_done(input string name, input int budget, output int done_cyc, output int rise_cyc);
        logic prev;
        prev     = 1'b1;
        done_cyc = -1;
        rise_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx_done && !prev && rise_cyc < 0) rise_cyc = cyc;
            prev = tx_done;
            if (o_done != 0 || o_error) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL %s_end: got no done/error within %0d cycles", name, budget);
        end else begin
            $display("finish %s: done=%b error=%b cycle=%0d", name, o_done, o_error, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"}, o_ack, 0);
        check({name, "_done"}, o_done, 0);
        check({name, "_error"}, o_error, 0);
        check({name, "_valid"}, o_tx_valid, 0);
        check({name, "_data"}, o_tx_data, 0);
        check({name, "_busy"}, o_busy, 1);
    endtask

    initial begin
        int ac, dc, rc, t0;
        bit stray;
        int seq[4];
        logic [NR-1:0] onehot;
        logic [NB-1:0] byte_exp;

        // Pointer enters the table at 1 (after the holdoff test grants requester 0).
        vecs[0] = '{4'b0001, 32'h13121110, 0};
        vecs[1] = '{4'b1001, 32'h23222120, 3};
        vecs[2] = '{4'b1111, 32'h33323130, 0};
        vecs[3] = '{4'b0101, 32'h43424140, 2};
        vecs[4] = '{4'b0110, 32'h53525150, 1};
        vecs[5] = '{4'b1000, 32'h63626160, 3};
        vecs[6] = '{4'b1100, 32'h73727170, 2};
        vecs[7] = '{4'b0011, 32'h83828180, 0};
        vecs[8] = '{4'b1010, 32'h93929190, 1};
        vecs[9] = '{4'b0111, 32'hA3A2A1A0, 2};
        seq = '{0, 2, 0, 2};

        reset = 1'b1;
        i_req = '0;
        i_data = '0;
        stub_clr = 1'b1;
        stub_hang = 1'b0;
        stub_delay = 20;
        repeat (3) @(negedge clock);
        stub_clr = 1'b0;
        check_reset_outputs("reset");

        // Request present right out of reset: accepted only after holdoff.
        t0 = cyc;
        reset = 1'b0;
        i_req = 4'b0001;
        i_data = 32'h000000E4;
        push_exp(0, 8'hE4);
        wait_ack("holdoff", FRAME + 50, ac, stray);
        check("holdoff_latency", ac - t0, FRAME + 1);
        i_req = '0;
        wait_done("holdoff", 200, dc, rc);
        check("holdoff_done", o_done, 4'b0001);
        check("holdoff_err", o_error, 0);
        check("holdoff_done_lat", dc - rc, 1);

        for (int v = 0; v < 10; v++) begin
            check("table_idle", o_busy, 0);
            i_req = vecs[v].req;
            i_data = vecs[v].dat;
            byte_exp = vecs[v].dat[vecs[v].idx*NB +: NB];
            push_exp(vecs[v].idx, byte_exp);
            wait_ack("table", 20, ac, stray);
            i_req = '0;
            wait_done("table", 200, dc, rc);
            onehot = '0;
            onehot[vecs[v].idx] = 1'b1;
            check("table_done", o_done, onehot);
            check("table_err", o_error, 0);
            check("table_data_hold", o_tx_data, byte_exp);
        end

        // Reset in the middle of WAIT: aborted byte never reports done.
        i_req = 4'b0010;
        i_data = 32'h00007700;
        push_exp(1, 8'h77);
        wait_ack("midrst", 20, ac, stray);
        i_req = '0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midrst");
        t0 = cyc;
        reset = 1'b0;
        i_req = 4'b1000;
        i_data = 32'hC5000000;
        push_exp(3, 8'hC5);
        wait_ack("rearm", FRAME + 50, ac, stray);
        check("rearm_latency", ac - t0, FRAME + 1);
        check("rearm_no_stale_done", stray, 0);
        i_req = '0;
        wait_done("rearm", 200, dc, rc);
        check("rearm_done", o_done, 4'b1000);

        // Two requesters held: strict alternation, launch two cycles after each done edge.
        i_req = 4'b0101;
        i_data = 32'h00330011;
        for (int k = 0; k < 4; k++) push_exp(seq[k], (seq[k] == 0) ? 8'h11 : 8'h33);
        for (int k = 0; k < 4; k++) begin
            wait_ack("b2b", 20, ac, stray);
            if (k > 0) check("b2b_gap", ac - rc, 2);
            if (k == 3) i_req = '0;
            wait_done("b2b", 200, dc, rc);
            onehot = '0;
            onehot[seq[k]] = 1'b1;
            check("b2b_done", o_done, onehot);
        end

        // Serializer never completes: watchdog abort, then pending requester granted.
        stub_hang = 1'b1;
        i_req = 4'b0001;
        i_data = 32'h00006B5A;
        push_exp(0, 8'h5A);
        wait_ack("wdog", 20, ac, stray);
        t0 = ac;
        i_req = 4'b0010;
        push_exp(1, 8'h6B);
        wait_done("wdog", TIMEOUT + 50, dc, rc);
        check("wdog_error", o_error, 1);
        check("wdog_no_done", o_done, 0);
        check("wdog_latency", dc - t0, TIMEOUT);
        stub_hang = 1'b0;
        wait_ack("wdog_next", 10, ac, stray);
        check("wdog_next_lat", ac - dc, 1);
        i_req = '0;
        wait_done("wdog_next", 200, dc, rc);
        check("wdog_next_done", o_done, 4'b0010);

        // Done edge lands on the cycle the watchdog expires: done wins.
        stub_delay = TIMEOUT - 2;
        i_req = 4'b0001;
        i_data = 32'h0000003C;
        push_exp(0, 8'h3C);
        wait_ack("race", 20, ac, stray);
        t0 = ac;
        i_req = '0;
        wait_done("race", TIMEOUT + 50, dc, rc);
        check("race_done", o_done, 4'b0001);
        check("race_err", o_error, 0);
        check("race_latency", dc - t0, TIMEOUT);
        check("race_done_lat", dc - rc, 1);
        stub_delay = 20;

        @(negedge clock);
        check("final_idle", o_busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
